// File: rtl/cmd_time_scheduler.sv
// -----------------------------------------------------------------------------
// cmd_time_scheduler
//
// Scans the command registry one address at a time. For each slot it fetches
// the 338-bit entry and compares its TIME_START with SYS_TIME. A slot that has
// come due is offered to the pulse controller over CMD_VALID/CMD_READY. After
// the consumer accepts it, the block asks the writer side to erase the slot
// over CLR_REQ/CLR_ACK, and then the scan continues at the next address.
//
// Optional feature: define SCHED_LATE_DROP_EN to drop entries that are more
// than LATE_WIN ticks overdue. A dropped entry goes straight to the erase step
// without being issued.
//
// Ports
//   CLK, rst_n            clock; asynchronous active-low reset
//   EN                    scan enable
//   SYS_TIME[63:0]        running system time, unsigned
//   RD_EN, RD_ADDR, RD_Q  registry read port (data valid one cycle after RD_EN)
//   CMD_VALID/READY       command handshake; CMD_DATA/CMD_ADDR = entry and slot
//   CLR_REQ/ACK, CLR_ADDR slot-erase handshake towards the writer
//   BUSY                  FSM is not idle
//   ISSUE_CNT[15:0]       issued commands, saturating
//   LATE_DROP             one-cycle pulse per dropped late entry
//   DROP_CNT[15:0]        dropped entries, saturating
// -----------------------------------------------------------------------------
module cmd_time_scheduler #(
  parameter int N_IDX    = 256,
  parameter int AW       = 8,
  parameter int W        = 338,
  parameter int LATE_WIN = 1000
) (
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          EN,
  input  logic [63:0]   SYS_TIME,
  output logic          RD_EN,
  output logic [AW-1:0] RD_ADDR,
  input  logic [W-1:0]  RD_Q,
  output logic          CMD_VALID,
  input  logic          CMD_READY,
  output logic [W-1:0]  CMD_DATA,
  output logic [AW-1:0] CMD_ADDR,
  output logic          CLR_REQ,
  output logic [AW-1:0] CLR_ADDR,
  input  logic          CLR_ACK,
  output logic          BUSY,
  output logic [15:0]   ISSUE_CNT,
  output logic          LATE_DROP,
  output logic [15:0]   DROP_CNT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CHECK = 3'd2,
    S_ISSUE = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  localparam logic [63:0] EMPTY_TIME = 64'hFFFF_FFFF_FFFF_FFFF;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [W-1:0]  cmd_data_q, cmd_data_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [15:0]   issue_cnt_q, issue_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          late_drop;

  logic [63:0]   time_start;
  logic          due;
  logic          late;
  logic [AW-1:0] addr_next;

  // TIME_START occupies the top 64 bits of the entry.
  assign time_start = RD_Q[W-1 -: 64];
  assign due        = (time_start != EMPTY_TIME) && (time_start <= SYS_TIME);

`ifdef SCHED_LATE_DROP_EN
  // The subtraction is only meaningful when due, so it never underflows.
  assign late = due && ((SYS_TIME - time_start) > 64'(LATE_WIN));
`else
  logic unused_late_win;
  assign late            = 1'b0;
  assign unused_late_win = ^64'(LATE_WIN);
`endif

  // Wrap explicitly so N_IDX need not be a power of two.
  assign addr_next = (addr_q == AW'(N_IDX - 1)) ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_addr_d  = cmd_addr_q;
    issue_cnt_d = issue_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    late_drop   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (EN) state_d = S_READ;
      end

      S_READ: begin
        state_d = S_CHECK;
      end

      S_CHECK: begin
        if (due) begin
          // Latched even for a dropped entry so CLR_ADDR points at the slot.
          cmd_data_d = RD_Q;
          cmd_addr_d = addr_q;
          if (late) begin
            late_drop = 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            state_d = S_CLEAR;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          addr_d  = addr_next;
          state_d = EN ? S_READ : S_IDLE;
        end
      end

      S_ISSUE: begin
        if (CMD_READY) begin
          if (issue_cnt_q != 16'hFFFF) issue_cnt_d = issue_cnt_q + 16'd1;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        if (CLR_ACK) begin
          addr_d  = addr_next;
          state_d = EN ? S_READ : S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cmd_data_q  <= '0;
      cmd_addr_q  <= '0;
      issue_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_addr_q  <= cmd_addr_d;
      issue_cnt_q <= issue_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Handshake outputs decode straight from the state register, so they drop
  // as soon as reset forces the FSM back to IDLE.
  assign RD_EN     = (state_q == S_READ);
  assign RD_ADDR   = addr_q;
  assign CMD_VALID = (state_q == S_ISSUE);
  assign CMD_DATA  = cmd_data_q;
  assign CMD_ADDR  = cmd_addr_q;
  assign CLR_REQ   = (state_q == S_CLEAR);
  assign CLR_ADDR  = cmd_addr_q;
  assign BUSY      = (state_q != S_IDLE);
  assign ISSUE_CNT = issue_cnt_q;

`ifdef SCHED_LATE_DROP_EN
  assign LATE_DROP = late_drop;
  assign DROP_CNT  = drop_cnt_q;
`else
  logic unused_drop;
  assign LATE_DROP   = 1'b0;
  assign DROP_CNT    = 16'd0;
  assign unused_drop = late_drop ^ (^drop_cnt_q);
`endif

endmodule

// File: tb/tb_cmd_time_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for cmd_time_scheduler. It holds a registry memory with a
// registered read port. A small reference model predicts which slot is served
// next, scanning in order from the current pointer, and how many cycles that
// takes: two per skipped slot.
// -----------------------------------------------------------------------------
module tb_cmd_time_scheduler;

  localparam int N_IDX = 256;
  localparam int AW = 8;
  localparam int W = 338;
  localparam int LATE_WIN = 1000;
`ifdef SCHED_LATE_DROP_EN
  localparam bit DROP_ON = 1'b1;
`else
  localparam bit DROP_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          rst_n = 1'b0;
  logic          EN = 1'b0;
  logic [63:0]   SYS_TIME = 64'd0;
  logic          RD_EN;
  logic [AW-1:0] RD_ADDR;
  logic [W-1:0]  RD_Q = '0;
  logic          CMD_VALID;
  logic          CMD_READY = 1'b0;
  logic [W-1:0]  CMD_DATA;
  logic [AW-1:0] CMD_ADDR;
  logic          CLR_REQ;
  logic [AW-1:0] CLR_ADDR;
  logic          CLR_ACK = 1'b0;
  logic          BUSY;
  logic [15:0]   ISSUE_CNT;
  logic          LATE_DROP;
  logic [15:0]   DROP_CNT;

  int n_checks = 0;
  int n_err = 0;
  bit ramp = 1'b0;
  logic [W-1:0] mem [N_IDX];

  cmd_time_scheduler #(.N_IDX(N_IDX), .AW(AW), .W(W), .LATE_WIN(LATE_WIN)) dut (
    .CLK(CLK), .rst_n(rst_n), .EN(EN), .SYS_TIME(SYS_TIME),
    .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_Q(RD_Q),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_DATA(CMD_DATA), .CMD_ADDR(CMD_ADDR),
    .CLR_REQ(CLR_REQ), .CLR_ADDR(CLR_ADDR), .CLR_ACK(CLR_ACK),
    .BUSY(BUSY), .ISSUE_CNT(ISSUE_CNT), .LATE_DROP(LATE_DROP), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  // Registry read port: data valid the cycle after RD_EN.
  always @(posedge CLK) if (RD_EN) RD_Q <= mem[RD_ADDR];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (ramp) SYS_TIME = SYS_TIME + 64'd1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N_IDX; i++) mem[i] = '1;
  endtask

  function automatic logic [W-1:0] mk_entry(input logic [63:0] ts);
    logic [351:0] t;
    logic [W-1:0] e;
    for (int k = 0; k < 11; k++) t[k*32 +: 32] = $urandom;
    e = t[W-1:0];
    e[W-1 -: 64] = ts;
    return e;
  endfunction

  // Leaves the DUT just out of reset; the current sample shows IDLE.
  task automatic do_reset();
    rst_n = 1'b0; EN = 1'b0; CMD_READY = 1'b0; CLR_ACK = 1'b0; ramp = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // kind: 0 = nothing within budget, 1 = CMD_VALID, 2 = LATE_DROP
  task automatic wait_event(input int budget, output int kind, output int ticks);
    kind = 0; ticks = 0;
    while (ticks < budget && kind == 0) begin
      tick(); ticks++;
      if (CMD_VALID) kind = 1;
      else if (LATE_DROP) kind = 2;
    end
  endtask

  task automatic do_clear(input int clr_cycles, input logic [AW-1:0] exp_addr);
    for (int i = 0; i < clr_cycles; i++) begin
      check("clr_req", 338'(CLR_REQ), 338'(1));
      check("clr_addr", 338'(CLR_ADDR), 338'(exp_addr));
      check("no_valid_in_clear", 338'({CMD_VALID, LATE_DROP}), 338'(0));
      if (i == clr_cycles - 1) CLR_ACK = 1'b1;
      tick();
      CLR_ACK = 1'b0;
    end
    mem[exp_addr] = '1;    // the writer erases the slot on ack
    check("clr_req_drop", 338'(CLR_REQ), 338'(0));
  endtask

  task automatic do_issue(input int ready_low, input int clr_cycles, input logic [AW-1:0] exp_addr);
    logic [W-1:0] held;
    held = mem[exp_addr];
    for (int i = 0; i < ready_low; i++) begin
      tick();
      check("stall_valid", 338'(CMD_VALID), 338'(1));
      check("stall_data", CMD_DATA, held);
      check("stall_addr", 338'(CMD_ADDR), 338'(exp_addr));
    end
    CMD_READY = 1'b1;
    tick();
    CMD_READY = 1'b0;
    check("valid_drop", 338'(CMD_VALID), 338'(0));
    do_clear(clr_cycles, exp_addr);
  endtask

  // Reference model: first due slot at or after ptr in scan order.
  function automatic int find_due(input int ptr, input logic [63:0] s, output int skipped);
    logic [63:0] ts;
    for (int k = 0; k < N_IDX; k++) begin
      ts = mem[(ptr + k) % N_IDX][W-1 -: 64];
      if (ts != 64'hFFFF_FFFF_FFFF_FFFF && ts <= s) begin
        skipped = k;
        return (ptr + k) % N_IDX;
      end
    end
    skipped = N_IDX;
    return -1;
  endfunction

  typedef struct {
    int          slot;
    logic [63:0] ts;
    logic [63:0] sys;
    bit          exp_due;
    bit          exp_late;
  } vec_t;

  initial begin
    vec_t vecs[10];
    int kind, ticks, exp_ticks, exp_slot, skipped, cnt, ptr, from_idle, bad, reads, last_rd, exp_a;
    logic [63:0] s;

    vecs[0] = '{5,   64'd100, 64'd99, 1'b0, 1'b0};
    vecs[1] = '{5,   64'd100, 64'd100, 1'b1, 1'b0};
    vecs[2] = '{0,   64'd0, 64'd0, 1'b1, 1'b0};
    vecs[3] = '{255, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[4] = '{10,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[5] = '{7,   64'd100, 64'd2000, 1'b1, 1'b1};
    vecs[6] = '{8,   64'd1000, 64'd2000, 1'b1, 1'b0};
    vecs[7] = '{9,   64'd1000, 64'd2001, 1'b1, 1'b1};
    vecs[8] = '{1,   64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[9] = '{2,   64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1};

    // Reset state, checked while reset is held.
    clear_mem();
    rst_n = 1'b0;
    tick();
    check("rst_outputs", 338'({RD_EN, CMD_VALID, CLR_REQ, BUSY, LATE_DROP}), 338'(0));
    check("rst_counts", 338'({ISSUE_CNT, DROP_CNT, RD_ADDR}), 338'(0));

    // Single-slot vectors.
    for (int v = 0; v < 10; v++) begin
      do_reset();
      clear_mem();
      mem[vecs[v].slot] = mk_entry(vecs[v].ts);
      SYS_TIME = vecs[v].sys;
      EN = 1'b1;
      wait_event(2 * N_IDX + 8, kind, ticks);
      if (!vecs[v].exp_due) begin
        check("vec_no_event", 338'(kind), 338'(0));
        check("vec_no_issue_cnt", 338'(ISSUE_CNT), 338'(0));
      end else if (vecs[v].exp_late && DROP_ON) begin
        check("vec_drop_kind", 338'(kind), 338'(2));
        check("vec_drop_time", 338'(ticks), 338'(2 + 2 * vecs[v].slot));
        if (kind == 2) begin
          tick();
          do_clear(2, AW'(vecs[v].slot));
        end
        check("vec_drop_cnt", 338'(DROP_CNT), 338'(1));
        check("vec_drop_issue_cnt", 338'(ISSUE_CNT), 338'(0));
      end else begin
        check("vec_issue_kind", 338'(kind), 338'(1));
        check("vec_issue_time", 338'(ticks), 338'(3 + 2 * vecs[v].slot));
        check("vec_issue_addr", 338'(CMD_ADDR), 338'(vecs[v].slot));
        check("vec_issue_data", CMD_DATA, mem[vecs[v].slot]);
        if (kind == 1) do_issue(0, 1, AW'(vecs[v].slot));
        check("vec_issue_cnt", 338'(ISSUE_CNT), 338'(1));
        check("vec_issue_dropcnt", 338'(DROP_CNT), 338'(0));
      end
      $display("vec %0d slot=%0d kind=%0d ticks=%0d", v, vecs[v].slot, kind, ticks);
    end

    // Empty registry: address walk and wrap.
    do_reset();
    clear_mem();
    EN = 1'b1;
    bad = 0; reads = 0; last_rd = -1; exp_a = 0;
    for (int t = 1; t <= 600; t++) begin
      tick();
      if (CMD_VALID) bad++;
      if (RD_EN) begin
        if (RD_ADDR != AW'(exp_a)) bad++;
        if (last_rd >= 0 && t - last_rd != 2) bad++;
        if (exp_a == 0 && reads > 0 && t != 513) bad++;
        last_rd = t;
        reads++;
        exp_a = (exp_a + 1) % N_IDX;
      end
    end
    check("walk_errors", 338'(bad), 338'(0));
    check("walk_reads", 338'(reads), 338'(300));
    $display("walk reads=%0d errors=%0d", reads, bad);

    // EN drop: the scan address is kept.
    while (!RD_EN) tick();
    exp_a = (int'(RD_ADDR) + 1) % N_IDX;
    EN = 1'b0;
    tick(); tick(); tick(); tick();
    check("en_low_idle", 338'({BUSY, RD_EN}), 338'(0));
    EN = 1'b1;
    tick();
    check("en_resume_addr", 338'({RD_EN, RD_ADDR}), 338'({1'b1, AW'(exp_a)}));

    // Slot 5 with SYS_TIME ramping from 50; stalls on both handshakes.
    do_reset();
    clear_mem();
    mem[5] = mk_entry(64'd100);
    SYS_TIME = 64'd50;
    ramp = 1'b1;
    EN = 1'b1;
    exp_ticks = 12;
    while (50 + exp_ticks < 100) exp_ticks += 2 * N_IDX;
    wait_event(3 * N_IDX, kind, ticks);
    ramp = 1'b0;
    check("ramp_kind", 338'(kind), 338'(1));
    check("ramp_time", 338'(ticks), 338'(exp_ticks + 1));
    check("ramp_addr", 338'(CMD_ADDR), 338'(5));
    check("ramp_data", CMD_DATA, mem[5]);
    if (kind == 1) do_issue(3, 4, 8'd5);
    check("ramp_issue_cnt", 338'(ISSUE_CNT), 338'(1));
    check("ramp_resume", 338'({RD_EN, RD_ADDR}), 338'({1'b1, 8'd6}));
    $display("ramp slot=5 ticks=%0d", ticks);

    // Two due slots: served in scan order.
    do_reset();
    clear_mem();
    mem[3] = mk_entry(64'd400);
    mem[200] = mk_entry(64'd10);
    SYS_TIME = 64'd500;
    EN = 1'b1;
    wait_event(2 * N_IDX + 8, kind, ticks);
    check("pair_first", 338'({kind[1:0], CMD_ADDR}), 338'({2'd1, 8'd3}));
    if (kind == 1) do_issue(1, 2, 8'd3);
    wait_event(2 * N_IDX + 8, kind, ticks);
    check("pair_second", 338'({kind[1:0], CMD_ADDR}), 338'({2'd1, 8'd200}));
    check("pair_data", CMD_DATA, mem[200]);
    if (kind == 1) do_issue(0, 1, 8'd200);
    check("pair_issue_cnt", 338'(ISSUE_CNT), 338'(2));
    $display("pair issued 3 then 200 cnt=%0d", ISSUE_CNT);

    // Reset while CMD_VALID is high.
    do_reset();
    clear_mem();
    mem[5] = mk_entry(64'd100);
    mem[20] = mk_entry(64'd100);
    SYS_TIME = 64'd500;
    EN = 1'b1;
    wait_event(2 * N_IDX + 8, kind, ticks);
    if (kind == 1) do_issue(0, 1, 8'd5);
    wait_event(2 * N_IDX + 8, kind, ticks);
    check("rstmid_valid_before", 338'({CMD_VALID, ISSUE_CNT}), 338'({1'b1, 16'd1}));
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_outputs", 338'({CMD_VALID, BUSY, CLR_REQ, ISSUE_CNT}), 338'(0));
    @(posedge CLK);
    #1 rst_n = 1'b1;
    tick();
    check("rstmid_restart", 338'({RD_EN, RD_ADDR}), 338'({1'b1, 8'd0}));
    $display("reset during issue handled");

    // Randomized registry against the reference model.
    do_reset();
    clear_mem();
    s = 64'h0000_1234_0000_0000 + 64'($urandom);
    for (int i = 0; i < N_IDX; i++)
      if ($urandom_range(7) == 0) mem[i] = mk_entry(s - 64'd500 + 64'($urandom_range(1000)));
    SYS_TIME = s;
    EN = 1'b1;
    ptr = 0; from_idle = 1; cnt = 0;
    for (int it = 0; it < 300; it++) begin
      exp_slot = find_due(ptr, s, skipped);
      wait_event(2 * N_IDX + 8, kind, ticks);
      if (exp_slot < 0) begin
        check("rand_quiet", 338'(kind), 338'(0));
        break;
      end
      check("rand_kind", 338'(kind), 338'(1));
      check("rand_addr", 338'(CMD_ADDR), 338'(exp_slot));
      check("rand_data", CMD_DATA, mem[exp_slot]);
      check("rand_time", 338'(ticks), 338'(2 * skipped + 2 + from_idle));
      if (kind != 1) break;
      do_issue(int'($urandom_range(3)), 1 + int'($urandom_range(3)), AW'(exp_slot));
      cnt++;
      check("rand_issue_cnt", 338'(ISSUE_CNT), 338'(cnt));
      $display("rand txn %0d slot=%0d skipped=%0d ticks=%0d", cnt, exp_slot, skipped, ticks);
      ptr = (exp_slot + 1) % N_IDX;
      from_idle = 0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cmd_time_scheduler.md
# cmd_time_scheduler

Downstream consumer of the command registry memory that the command writer fills with timed commands. The block scans the registry address by address, fetches each 338-bit entry and compares its TIME_START with the running system time. Each entry that has come due is presented to the synthesizer/pulse controller over a valid/ready handshake. The block then requests that the writer side erase the slot.

## Interface
- N_IDX, 256, number of registry entries
- AW, 8, registry address width
- W, 338, entry width; field packing MSB→LSB:
  - TIME_START[337:274], FREQ[273:226], FREQ_STEP[225:178], FREQ_RATE[177:146]
  - N_impuls[145:130], TYPE_impulse[129:128], Interval_Ti[127:96], Interval_Tp[95:64]
  - Tblank1[63:32], Tblank2[31:0]
- LATE_WIN, 1000, late tolerance in SYS_TIME ticks (used only with the macro)

Ports:
- CLK  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- EN  in  1  scan enable
- SYS_TIME  in  64  current system time, unsigned
- RD_EN  out  1  registry read strobe
- RD_ADDR  out  AW  registry read address
- RD_Q  in  W  registry read data; valid the cycle after RD_EN
- CMD_VALID  out  1  command available
- CMD_READY  in  1  consumer accepts command
- CMD_DATA  out  W  full entry of the issued command
- CMD_ADDR  out  AW  slot the command came from
- CLR_REQ  out  1  request to erase a slot
- CLR_ADDR  out  AW  slot to erase
- CLR_ACK  in  1  erase done
- BUSY  out  1  state is not IDLE
- ISSUE_CNT  out  16  issued commands; saturating counter
- LATE_DROP  out  1  one-cycle pulse when a late entry is dropped
- DROP_CNT  out  16  dropped entries; saturating counter

## Operation
- Empty slot: TIME_START == 64'hFFFF_FFFF_FFFF_FFFF. An empty slot is never due.
- Due: not empty and TIME_START <= SYS_TIME, unsigned 64-bit compare.
- FSM states: IDLE, READ, CHECK, ISSUE, CLEAR.
- IDLE: if EN=1, go to READ. Otherwise stay in IDLE; the scan address is retained.
- READ: RD_EN=1 for one cycle with RD_ADDR=scan address. Next state is CHECK.
- CHECK: RD_Q is sampled.
  - Not due: advance the address, then go to READ if EN=1, else IDLE.
  - Due: latch CMD_DATA←RD_Q and CMD_ADDR←address, then go to ISSUE.
- ISSUE: CMD_VALID=1. CMD_DATA and CMD_ADDR stay stable until CMD_READY=1 is sampled. On that cycle ISSUE_CNT increments and the state goes to CLEAR.
- CLEAR: CLR_REQ=1 and CLR_ADDR=CMD_ADDR until CLR_ACK=1 is sampled. Then advance the address and go to READ if EN=1, else IDLE.
- Address advance: +1, with N_IDX-1 wrapping to 0.
- Due entries are served in scan order starting from the current address.
- An ISSUE or CLEAR already in progress always completes, even if EN drops.
- CLR_ACK outside CLEAR and CMD_READY outside ISSUE are ignored.
- Coherence between a slot being cleared and the writer rewriting it is the writer's responsibility; this block only sequences issue before clear.

## Timing
- All outputs reset to 0, including the scan address and both counters; the FSM resets to IDLE. Assertion of rst_n is asynchronous. Reset during ISSUE or CLEAR abandons the transaction; CMD_VALID and CLR_REQ drop immediately.
- Scan rate: 2 cycles per entry that is not due, so a full pass takes 2·N_IDX cycles.
- Latency from the READ cycle to CMD_VALID high is 2 cycles (READ, CHECK, then ISSUE).
- CMD_READY high on the first ISSUE cycle gives a one-cycle handshake. CLR_REQ then rises on the next cycle.
- Counters saturate at 16'hFFFF.
- SYS_TIME is sampled only in CHECK.

## Configuration
- Macro SCHED_LATE_DROP_EN.
- Defined: in CHECK, a due entry with SYS_TIME − TIME_START > LATE_WIN is late. The difference is computed only for due entries, so it cannot underflow. A late entry skips ISSUE and goes straight to CLEAR. LATE_DROP pulses during the CHECK→CLEAR transition cycle and DROP_CNT increments. CMD_DATA and CMD_ADDR are still latched, so CLR_ADDR is correct.
- Not defined: late entries are issued normally. LATE_DROP and DROP_CNT are tied to 0 and LATE_WIN is unused.

## Test plan
- All slots empty, EN=1, 600 cycles → CMD_VALID stays 0; RD_ADDR walks 0..255, wraps to 0 at cycle 512, and repeats.
- Slot 5 holds TIME_START=100 and SYS_TIME ramps from 50 → no issue while SYS_TIME<100. On the first CHECK of slot 5 with SYS_TIME>=100: CMD_VALID=1, CMD_ADDR=5, CMD_DATA equals the entry.
- Backpressure in the slot-5 case: CMD_READY is held low for 3 cycles, then CLR_ACK is delayed 4 cycles.
  - CMD_DATA stays stable for all 3 cycles.
  - CLR_REQ with CLR_ADDR=5 lasts 4 cycles; ISSUE_CNT=1.
  - The scan resumes at address 6.
- Slots 3 and 200 are both due and the scan starts at 0 → slot 3 is issued and cleared before slot 200; ISSUE_CNT=2.
- Reset pulse while CMD_VALID=1 → CMD_VALID, BUSY and ISSUE_CNT are 0 during reset; after release, RD_ADDR restarts at 0.
- Slot 7 holds TIME_START=100 with SYS_TIME=2000 and LATE_WIN=1000:
  - With the macro: no CMD_VALID, LATE_DROP pulses once, CLR_ADDR=7, DROP_CNT=1.
  - Without the macro: issued normally.
